// File: rtl/mem_fill_arbiter.sv
// Arbitrates the shared pipelined main memory between I- and D-cache misses.
// Sequences WORDS-word block fills and single-cycle D-side write-through stores.
module mem_fill_arbiter #(
    parameter int WORDS  = 8,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_miss,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic                     d_miss,
    input  logic [ADDR_W-1:0]        d_addr,
    input  logic                     d_wr,
    input  logic [15:0]              d_wdata,
    input  logic [15:0]              mem_rdata,
    input  logic                     mem_valid,
    output logic                     mem_en,
    output logic                     mem_wr,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [15:0]              mem_wdata,
    output logic [15:0]              fill_data,
    output logic [$clog2(WORDS)-1:0] fill_idx,
    output logic                     i_fill_we,
    output logic                     d_fill_we,
    output logic                     i_done,
    output logic                     d_done,
    output logic                     busy
);

    localparam int IW = $clog2(WORDS);
    localparam logic [IW:0]       ISS_END  = (IW+1)'(WORDS);
    localparam logic [IW-1:0]     RET_LAST = IW'(WORDS - 1);
    localparam logic [ADDR_W-1:0] ALIGN    = ~ADDR_W'(2*WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STORE,
        S_FILL,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_owner;
    logic [IW:0]       r_iss;
    logic [IW-1:0]     r_ret;
    logic [ADDR_W-1:0] r_base;
    logic              w_issue;
    logic              w_ret;

    assign w_issue = (r_state == S_FILL) && (r_iss < ISS_END);
    assign w_ret   = (r_state == S_FILL) && mem_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_iss   <= '0;
            r_ret   <= '0;
            r_base  <= '0;
        end else begin
            r_state <= w_next;
            // D-side wins the grant; a store also claims the D owner slot
            if (r_state == S_IDLE) begin
                if (d_miss) begin
                    r_owner <= 1'b1;
                    r_base  <= d_addr & ALIGN;
                end else if (i_miss) begin
                    r_owner <= 1'b0;
                    r_base  <= i_addr & ALIGN;
                end
            end
            if (r_state == S_DONE) begin
                r_iss <= '0;
                r_ret <= '0;
            end else begin
                if (w_issue)
                    r_iss <= r_iss + 1'b1;
                if (w_ret)
                    r_ret <= r_ret + 1'b1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        fill_data = '0;
        fill_idx  = '0;
        i_fill_we = 1'b0;
        d_fill_we = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (d_miss)
                    w_next = d_wr ? S_STORE : S_FILL;
                else if (i_miss)
                    w_next = S_FILL;
            end
            S_STORE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                w_next    = S_DONE;
            end
            S_FILL: begin
                if (w_issue) begin
                    mem_en   = 1'b1;
                    mem_addr = r_base + ADDR_W'({r_iss, 1'b0});
                end
                fill_data = mem_rdata;
                fill_idx  = r_ret;
                i_fill_we = mem_valid & ~r_owner;
                d_fill_we = mem_valid & r_owner;
                if (mem_valid && r_ret == RET_LAST)
                    w_next = S_DONE;
            end
            S_DONE: begin
                i_done = ~r_owner;
                d_done = r_owner;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Scoreboard bench for mem_fill_arbiter with a latency-modelling memory.
// Expected reads and fill words are queued when a miss is raised.
module tb_mem_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, fill_data;
    logic [2:0]  fill_idx;
    logic        i_fill_we, d_fill_we, i_done, d_done, busy;

    always #5 clk = ~clk;

    mem_fill_arbiter #(.WORDS(8), .ADDR_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_miss    (i_miss),
        .i_addr    (i_addr),
        .d_miss    (d_miss),
        .d_addr    (d_addr),
        .d_wr      (d_wr),
        .d_wdata   (d_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .fill_data (fill_data),
        .fill_idx  (fill_idx),
        .i_fill_we (i_fill_we),
        .d_fill_we (d_fill_we),
        .i_done    (i_done),
        .d_done    (d_done),
        .busy      (busy)
    );

    typedef struct {
        logic        own;
        logic [2:0]  idx;
        logic [15:0] data;
    } fill_t;

    fill_t       q_fill[$];
    logic [15:0] q_addr[$];
    int          q_due[$];
    logic [15:0] q_dat[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc_n = 0;
    int last_due = 0;
    int lat_mode = 0;
    bit stray = 0;
    bit prev_rd = 0;
    int burst_start = 0;
    int n_fill = 0;
    int n_idone = 0;
    int n_ddone = 0;
    int d_done_cyc = 0;
    int n_store = 0;
    int store_cyc = 0;
    bit d_is_store = 0;
    int last_fill_cyc[2] = '{0, 0};
    logic [15:0] exp_st_addr, exp_st_data;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mdat(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic exp_fill(input logic own, input logic [15:0] a);
        logic [15:0] base;
        base = a & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            q_addr.push_back(base + 16'(2*k));
            q_fill.push_back('{own, 3'(k), mdat(base + 16'(2*k))});
        end
    endtask

    function automatic int left(input logic own);
        int n = 0;
        foreach (q_fill[k])
            if (q_fill[k].own == own)
                n++;
        return n;
    endfunction

    task automatic cyc();
        fill_t       e;
        logic [63:0] ea;
        int          due;
        bit          rd;
        @(negedge clk);
        cyc_n++;
        mem_valid = 1'b0;
        mem_rdata = 16'h0000;
        if (q_due.size() > 0 && q_due[0] <= cyc_n) begin
            mem_valid = 1'b1;
            mem_rdata = q_dat.pop_front();
            void'(q_due.pop_front());
        end else if (stray) begin
            mem_valid = 1'b1;
            mem_rdata = 16'hDEAD;
        end
        #1;
        rd = (mem_en === 1'b1) && (mem_wr === 1'b0);
        if (rd) begin
            if (!prev_rd)
                burst_start = cyc_n;
            ea = (q_addr.size() > 0) ? 64'(q_addr.pop_front()) : '1;
            chk("rd_addr", 64'(mem_addr), ea);
            if (lat_mode == 0)
                due = cyc_n + 4;
            else
                due = ((last_due > cyc_n) ? last_due : cyc_n)
                      + 1 + int'($urandom_range(0, 3));
            last_due = due;
            q_due.push_back(due);
            q_dat.push_back(mdat(mem_addr));
        end
        prev_rd = rd;
        if (mem_en === 1'b1 && mem_wr === 1'b1) begin
            n_store++;
            store_cyc = cyc_n;
            chk("st_addr", 64'(mem_addr), 64'(exp_st_addr));
            chk("st_data", 64'(mem_wdata), 64'(exp_st_data));
        end
        if (stray && mem_valid && q_fill.size() == 0)
            chk("stray_we", {i_fill_we, d_fill_we}, 0);
        else if (i_fill_we || d_fill_we) begin
            if (q_fill.size() == 0)
                chk("fill_spurious", {i_fill_we, d_fill_we}, 0);
            else begin
                e = q_fill.pop_front();
                n_fill++;
                last_fill_cyc[e.own] = cyc_n;
                chk("fill_we", {i_fill_we, d_fill_we},
                    e.own ? 64'd1 : 64'd2);
                chk("fill_idx", 64'(fill_idx), 64'(e.idx));
                chk("fill_data", 64'(fill_data), 64'(e.data));
            end
        end
        if (i_done === 1'b1) begin
            n_idone++;
            chk("i_done_gap", 64'(cyc_n - last_fill_cyc[0]), 1);
            chk("i_left", 64'(left(1'b0)), 0);
            i_miss = 1'b0;
        end
        if (d_done === 1'b1) begin
            n_ddone++;
            d_done_cyc = cyc_n;
            chk("d_done_gap", 64'(cyc_n -
                (d_is_store ? store_cyc : last_fill_cyc[1])), 1);
            chk("d_left", 64'(left(1'b1)), 0);
            d_miss = 1'b0;
            d_wr   = 1'b0;
        end
    endtask

    task automatic wait_done(input bit d, input int target);
        for (int k = 0; k < 300; k++) begin
            if ((d ? n_ddone : n_idone) >= target)
                break;
            cyc();
        end
        chk(d ? "d_done_cnt" : "i_done_cnt",
            64'(d ? n_ddone : n_idone), 64'(target));
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {mem_en, mem_wr, mem_addr, mem_wdata, fill_data,
                  fill_idx, i_fill_we, d_fill_we, i_done, d_done,
                  busy}, 0);
    endtask

    int snap;

    initial begin
        rst       = 1'b1;
        i_miss    = 1'b0;
        d_miss    = 1'b0;
        d_wr      = 1'b0;
        i_addr    = '0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_valid = 1'b0;
        mem_rdata = '0;
        exp_st_addr = '0;
        exp_st_data = '0;
        repeat (2) cyc();
        chk_zero("reset_outs");
        rst = 1'b0;
        cyc();

        // I fill, latency 4
        exp_fill(1'b0, 16'h0036);
        i_addr = 16'h0036;
        i_miss = 1'b1;
        wait_done(1'b0, 1);
        chk("i_only_dd", 64'(n_ddone), 0);
        cyc();
        chk("idle_busy1", 64'(busy), 0);

        // simultaneous misses: D first, I after one IDLE cycle
        exp_fill(1'b1, 16'h1002);
        exp_fill(1'b0, 16'h0104);
        d_addr = 16'h1002;
        d_wr   = 1'b0;
        i_addr = 16'h0104;
        d_miss = 1'b1;
        i_miss = 1'b1;
        wait_done(1'b1, 1);
        snap = d_done_cyc;
        wait_done(1'b0, 2);
        chk("grant_gap", 64'(burst_start - snap), 2);
        cyc();
        chk("idle_busy2", 64'(busy), 0);

        // store with stray mem_valid during STORE
        d_is_store  = 1'b1;
        exp_st_addr = 16'h2004;
        exp_st_data = 16'hBEEF;
        d_addr  = 16'h2004;
        d_wdata = 16'hBEEF;
        d_wr    = 1'b1;
        d_miss  = 1'b1;
        stray   = 1'b1;
        snap    = n_fill;
        wait_done(1'b1, 2);
        repeat (3) cyc();
        stray = 1'b0;
        d_is_store = 1'b0;
        chk("n_store", 64'(n_store), 1);
        chk("stray_cnt", 64'(n_fill), 64'(snap));
        chk("idle_busy3", 64'(busy), 0);

        // reset after 3 returned words, then re-issue
        exp_fill(1'b0, 16'h0400);
        i_addr = 16'h0400;
        i_miss = 1'b1;
        snap   = n_fill;
        for (int k = 0; k < 100 && n_fill < snap + 3; k++)
            cyc();
        chk("pre_rst_cnt", 64'(n_fill), 64'(snap + 3));
        rst = 1'b1;
        #1;
        chk_zero("rst_mid_fill");
        q_fill.delete();
        q_addr.delete();
        q_due.delete();
        q_dat.delete();
        last_due = 0;
        repeat (2) cyc();
        rst = 1'b0;
        exp_fill(1'b0, 16'h0400);
        wait_done(1'b0, 3);

        // irregular latency
        lat_mode = 1;
        exp_fill(1'b1, 16'h3ABC);
        d_addr = 16'h3ABC;
        d_wr   = 1'b0;
        d_miss = 1'b1;
        wait_done(1'b1, 3);
        exp_fill(1'b0, 16'hFFF2);
        i_addr = 16'hFFF2;
        i_miss = 1'b1;
        wait_done(1'b0, 4);
        cyc();
        chk("idle_busy4", 64'(busy), 0);
        chk("q_empty", 64'(q_fill.size() + q_addr.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
